// File: rtl/regfile_port_scheduler_if.sv
// Pipeline-side handshake bundle for the register-file port-A scheduler:
// two writers (W0 ALU writeback, W1 load return) and one port-A reader.
interface regfile_port_scheduler_if;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;

  logic              w0_valid;
  logic              w0_ready;
  logic [ADDR_W-1:0] w0_addr;
  logic [DATA_W-1:0] w0_data;

  logic              w1_valid;
  logic              w1_ready;
  logic [ADDR_W-1:0] w1_addr;
  logic [DATA_W-1:0] w1_data;

  logic              ra_valid;
  logic              ra_ready;
  logic [ADDR_W-1:0] ra_addr;
  logic [DATA_W-1:0] ra_data;

  modport master (
    output w0_valid, w0_addr, w0_data,
    output w1_valid, w1_addr, w1_data,
    output ra_valid, ra_addr,
    input  w0_ready, w1_ready, ra_ready, ra_data
  );

  modport slave (
    input  w0_valid, w0_addr, w0_data,
    input  w1_valid, w1_addr, w1_data,
    input  ra_valid, ra_addr,
    output w0_ready, w1_ready, ra_ready, ra_data
  );
endinterface

// File: rtl/regfile_port_scheduler.sv
// Arbitrates the single write-or-read port A of the 64x16 register file between two
// writers and one reader: reads win by default, starved writes force a bounded burst.
module regfile_port_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned WRITE_BURST  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  regfile_port_scheduler_if.slave   bus,
  output logic                      o_rf_we,
  output logic [5:0]                o_rf_addr_a,
  output logic [15:0]               o_rf_wdata,
  input  logic [15:0]               i_rf_rd_data
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BURST_W  = $clog2(WRITE_BURST + 1);

  typedef enum logic {
    READ_PRI  = 1'b0,
    WRITE_PRI = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_rr_w1;
  logic [STARVE_W-1:0] r_starve;
  logic [BURST_W-1:0]  r_burst;
  logic                r_arm;
  logic                r_active;

  state_t              w_state_nxt;
  logic                w_rr_nxt;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic [BURST_W-1:0]  w_burst_nxt;
  logic [STARVE_W-1:0] w_starve_inc;
  logic [BURST_W-1:0]  w_burst_inc;
  logic                w_any_wv;
  logic                w_sel_w1;
  logic                w_grant_wr;
  logic                w_grant_rd;

  assign w_any_wv     = bus.w0_valid | bus.w1_valid;
  assign w_sel_w1     = (bus.w0_valid & bus.w1_valid) ? r_rr_w1 : bus.w1_valid;
  assign w_starve_inc = r_starve + STARVE_W'(1);
  assign w_burst_inc  = r_burst + BURST_W'(1);

  // Grant selection; nothing is granted until the post-reset arming completes.
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (r_active) begin
      case (r_state)
        READ_PRI: begin
          w_grant_rd = bus.ra_valid;
          w_grant_wr = ~bus.ra_valid & w_any_wv;
        end
        WRITE_PRI: begin
          w_grant_wr = w_any_wv;
          w_grant_rd = ~w_any_wv & bus.ra_valid;
        end
      endcase
    end
  end

  assign bus.w0_ready = w_grant_wr & ~w_sel_w1;
  assign bus.w1_ready = w_grant_wr & w_sel_w1;
  assign bus.ra_ready = w_grant_rd;
  assign bus.ra_data  = i_rf_rd_data;

  // Port-A mux: the granted writer owns address and data, otherwise the reader's address.
  always_comb begin
    o_rf_we     = w_grant_wr;
    o_rf_addr_a = bus.ra_addr;
    o_rf_wdata  = 16'h0000;
    if (w_grant_wr) begin
      o_rf_addr_a = w_sel_w1 ? bus.w1_addr : bus.w0_addr;
      o_rf_wdata  = w_sel_w1 ? bus.w1_data : bus.w0_data;
    end
  end

  // Next-state: starvation count in READ_PRI, burst count in WRITE_PRI.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr_w1;
    w_starve_nxt = r_starve;
    w_burst_nxt  = r_burst;
    if (w_grant_wr) w_rr_nxt = ~w_sel_w1;
    if (r_active) begin
      case (r_state)
        READ_PRI: begin
          if (w_grant_wr) begin
            w_starve_nxt = '0;
          end else if (w_any_wv) begin
            if (w_starve_inc == STARVE_W'(STARVE_LIMIT)) begin
              w_state_nxt  = WRITE_PRI;
              w_starve_nxt = '0;
              w_burst_nxt  = '0;
            end else begin
              w_starve_nxt = w_starve_inc;
            end
          end
        end
        WRITE_PRI: begin
          if (w_any_wv && (w_burst_inc != BURST_W'(WRITE_BURST))) begin
            w_burst_nxt = w_burst_inc;
          end else begin
            w_state_nxt  = READ_PRI;
            w_starve_nxt = '0;
            w_burst_nxt  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= READ_PRI;
      r_rr_w1  <= 1'b0;
      r_starve <= '0;
      r_burst  <= '0;
      r_arm    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_w1  <= w_rr_nxt;
      r_starve <= w_starve_nxt;
      r_burst  <= w_burst_nxt;
      r_arm    <= 1'b1;
      r_active <= r_arm;
    end
  end

endmodule
